// File: rtl/div_iter.sv
// div_iter: iterative unsigned restoring divider for the dataflow operator
// library. Dividend on port 1, divisor on port 2. A quotient/remainder pair is
// produced N enabled edges after acceptance. The library protocol has no
// backpressure, so operand pairs that arrive mid-division are discarded and
// flagged on DROP.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   EN           global enable; all state and outputs hold while low
//   R_IN1/D_IN1  dividend valid / dividend
//   R_IN2/D_IN2  divisor valid / divisor
//   R_OUT        result valid pulse (stretches while EN=0)
//   D_OUT/D_REM  quotient / remainder, held between results
//   DZ           divide-by-zero, qualified by R_OUT
//   BUSY         division in progress
//   DROP         operand pair discarded because BUSY
module div_iter #(
   parameter int N = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic         R_IN1,
   input  logic [N-1:0] D_IN1,
   input  logic         R_IN2,
   input  logic [N-1:0] D_IN2,
   output logic         R_OUT,
   output logic [N-1:0] D_OUT,
   output logic [N-1:0] D_REM,
   output logic         DZ,
   output logic         BUSY,
   output logic         DROP
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE, ITER} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [N-1:0]   dvsr, dvsr_nxt;
   logic [N-1:0]   q, q_nxt;
   logic [N-1:0]   rem, rem_nxt;
   logic           r_out_nxt, dz_nxt, busy_nxt, drop_nxt;
   logic [N-1:0]   d_out_nxt, d_rem_nxt;

   logic           pair;
   logic [N-1:0]   shifted;
   logic [N:0]     trial;
   logic [N-1:0]   q_step, rem_step;

   // The partial remainder stays below 2^(N-1) on every step but the last
   // (it is bounded by the dividend bits consumed so far), so dropping
   // rem[N-1] when shifting never loses information.
   assign pair    = R_IN1 & R_IN2;
   assign shifted = {rem[N-2:0], q[N-1]};
   assign trial   = {1'b0, shifted} - {1'b0, dvsr};

   // trial[N] is the borrow: set means the divisor did not fit.
   always_comb begin
      q_step   = {q[N-2:0], ~trial[N]};
      rem_step = trial[N] ? shifted : trial[N-1:0];
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dvsr_nxt  = dvsr;
      q_nxt     = q;
      rem_nxt   = rem;
      r_out_nxt = 1'b0;
      drop_nxt  = 1'b0;
      d_out_nxt = D_OUT;
      d_rem_nxt = D_REM;
      dz_nxt    = DZ;
      busy_nxt  = BUSY;
      case (state)
         IDLE: begin
            if (pair) begin
               if (D_IN2 != '0) begin
                  dvsr_nxt  = D_IN2;
                  q_nxt     = D_IN1;
                  rem_nxt   = '0;
                  cnt_nxt   = CW'(N);
                  state_nxt = ITER;
                  busy_nxt  = 1'b1;
               end else begin
                  // zero divisor bypasses the iteration entirely
                  r_out_nxt = 1'b1;
                  d_out_nxt = '0;
                  d_rem_nxt = D_IN1;
                  dz_nxt    = 1'b1;
               end
            end
         end
         ITER: begin
            drop_nxt = pair;
            q_nxt    = q_step;
            rem_nxt  = rem_step;
            cnt_nxt  = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               d_out_nxt = q_step;
               d_rem_nxt = rem_step;
               dz_nxt    = 1'b0;
               r_out_nxt = 1'b1;
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         cnt   <= '0;
         dvsr  <= '0;
         q     <= '0;
         rem   <= '0;
         R_OUT <= 1'b0;
         D_OUT <= '0;
         D_REM <= '0;
         DZ    <= 1'b0;
         BUSY  <= 1'b0;
         DROP  <= 1'b0;
      end else if (EN) begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         dvsr  <= dvsr_nxt;
         q     <= q_nxt;
         rem   <= rem_nxt;
         R_OUT <= r_out_nxt;
         D_OUT <= d_out_nxt;
         D_REM <= d_rem_nxt;
         DZ    <= dz_nxt;
         BUSY  <= busy_nxt;
         DROP  <= drop_nxt;
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter (N=16): vector table plus hand-written sequences for
// busy/drop, back-to-back, stall and mid-operation reset. Expected results
// are queued when an accepted operand pair is driven and checked by a
// monitor on each new R_OUT pulse.
module tb_div_iter;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b1;
   logic         r_in1 = 1'b0, r_in2 = 1'b0;
   logic [N-1:0] d_in1 = '0, d_in2 = '0;
   logic         r_out, dz, busy, drop;
   logic [N-1:0] d_out, d_rem;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
   } res_t;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
   } vec_t;

   res_t sb[$];
   logic en_last;

   div_iter #(.N(N)) dut (
      .CLK  (clk),
      .RST  (rst_n),
      .EN   (en),
      .R_IN1(r_in1),
      .D_IN1(d_in1),
      .R_IN2(r_in2),
      .D_IN2(d_in2),
      .R_OUT(r_out),
      .D_OUT(d_out),
      .D_REM(d_rem),
      .DZ   (dz),
      .BUSY (busy),
      .DROP (drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // a pulse is new only if the preceding edge was enabled
   always @(posedge clk or negedge rst_n)
      if (!rst_n) en_last <= 1'b0;
      else        en_last <= en;

   always @(negedge clk) begin
      res_t e;
      if (rst_n && r_out && en_last) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_r_out: got q=%0h r=%0h expected no result", d_out, d_rem);
         end else begin
            e = sb.pop_front();
            chk("res_q", d_out, e.q);
            chk("res_r", d_rem, e.r);
            chk("res_dz", dz, e.dz);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // called just after a negedge; holds both valids for one edge
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
      res_t e;
      d_in1 = a;
      d_in2 = b;
      r_in1 = 1'b1;
      r_in2 = 1'b1;
      if (push) begin
         e.q  = (b == 0) ? '0 : N'(a / b);
         e.r  = (b == 0) ? a  : N'(a % b);
         e.dz = (b == 0);
         sb.push_back(e);
      end
      step();
      r_in1 = 1'b0;
      r_in2 = 1'b0;
   endtask

   task automatic wait_result(input string name, input int maxc);
      int k = 0;
      while (sb.size() != 0 && k < maxc) begin
         step();
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[12];
      int busy_cnt, first, k;

      vecs[0]  = '{16'd100,   16'd7,      16'd14,    16'd2,      1'b0};
      vecs[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,  16'd0,      1'b0};
      vecs[2]  = '{16'd5,     16'd9,      16'd0,     16'd5,      1'b0};
      vecs[3]  = '{16'hFFFF,  16'hFFFF,   16'd1,     16'd0,      1'b0};
      vecs[4]  = '{16'd0,     16'd3,      16'd0,     16'd0,      1'b0};
      vecs[5]  = '{16'h1234,  16'd0,      16'd0,     16'h1234,   1'b1};
      vecs[6]  = '{16'd12345, 16'd123,    16'd100,   16'd45,     1'b0};
      vecs[7]  = '{16'hFFFE,  16'hFFFF,   16'd0,     16'hFFFE,   1'b0};
      vecs[8]  = '{16'hFFFF,  16'h8001,   16'd1,     16'h7FFE,   1'b0};
      vecs[9]  = '{16'hFFFF,  16'd2,      16'h7FFF,  16'd1,      1'b0};
      vecs[10] = '{16'd1000,  16'd33,     16'd30,    16'd10,     1'b0};
      vecs[11] = '{16'd0,     16'd0,      16'd0,     16'd0,      1'b1};

      // reset state
      step();
      step();
      chk("rst_r_out", r_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop, 0);
      chk("rst_d_out", d_out, 0);
      chk("rst_d_rem", d_rem, 0);
      chk("rst_dz", dz, 0);
      rst_n = 1'b1;
      step();

      // single valid is ignored
      r_in1 = 1'b1;
      d_in1 = 16'd9;
      d_in2 = 16'd3;
      step();
      r_in1 = 1'b0;
      chk("one_valid_busy", busy, 0);
      step();
      chk("one_valid_r_out", r_out, 0);

      // basic division: busy width and latency
      issue(16'd100, 16'd7, 1);
      busy_cnt = 0;
      first = 0;
      for (int i = 1; i <= 20; i++) begin
         if (busy) busy_cnt++;
         if (r_out && first == 0) first = i;
         step();
      end
      chk("basic_busy_cycles", busy_cnt, 16);
      chk("basic_latency", first, 17);
      wait_result("basic", 5);

      // divide by zero: one-edge latency, never busy
      issue(16'h1234, 16'd0, 1);
      chk("dz_r_out", r_out, 1);
      chk("dz_busy", busy, 0);
      step();
      chk("dz_r_out_clear", r_out, 0);
      wait_result("dz", 5);

      // vector table
      foreach (vecs[i]) begin
         res_t e;
         d_in1 = vecs[i].a;
         d_in2 = vecs[i].b;
         r_in1 = 1'b1;
         r_in2 = 1'b1;
         e.q   = vecs[i].q;
         e.r   = vecs[i].r;
         e.dz  = vecs[i].dz;
         sb.push_back(e);
         step();
         r_in1 = 1'b0;
         r_in2 = 1'b0;
         wait_result("vec", N + 4);
      end

      // held values between results
      step();
      step();
      chk("hold_d_out", d_out, 0);
      chk("hold_dz", dz, 1);

      // busy drop, then back-to-back accept in the R_OUT cycle
      issue(16'd50, 16'd5, 1);
      step();
      step();
      issue(16'd9, 16'd3, 0);
      chk("drop_pulse", drop, 1);
      step();
      chk("drop_clear", drop, 0);
      chk("drop_busy", busy, 1);
      k = 0;
      while (!r_out && k < 30) begin
         step();
         k++;
      end
      chk("b2b_first_r_out", r_out, 1);
      issue(16'd9, 16'd3, 1);
      chk("b2b_accept_busy", busy, 1);
      chk("b2b_r_out_clear", r_out, 0);
      chk("b2b_no_drop", drop, 0);
      wait_result("b2b", N + 4);

      // stall mid-iteration and during the R_OUT cycle
      issue(16'd1000, 16'd33, 1);
      first = 0;
      for (int i = 1; i <= 30 && first == 0; i++) begin
         if (i == 6)  en = 1'b0;
         if (i == 11) en = 1'b1;
         if (r_out) first = i;
         else step();
      end
      chk("stall_latency", first, 22);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_r_out_hold", r_out, 1);
      end
      en = 1'b1;
      step();
      chk("stall_r_out_clear", r_out, 0);
      wait_result("stall", 5);

      // async reset mid-operation
      issue(16'd5000, 16'd7, 0);
      repeat (7) step();
      chk("abort_busy_before", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_d_out", d_out, 0);
      chk("abort_d_rem", d_rem, 0);
      chk("abort_dz", dz, 0);
      chk("abort_r_out", r_out, 0);
      step();
      rst_n = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (r_out) busy_cnt++;
         step();
      end
      chk("abort_no_r_out", busy_cnt, 0);
      issue(16'd7, 16'd2, 1);
      wait_result("after_abort", N + 4);

      step();
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
